banked_regfile: RTL and testbench

BANKED_REGFILE -- requirements
Module: banked_regfile

---
 rtl/banked_regfile_pkg.sv | 41 ++++
 rtl/banked_regfile_bank_map.sv | 61 ++++++
 rtl/banked_regfile.sv | 100 ++++++++++
 tb/tb_banked_regfile.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/banked_regfile_pkg.sv
// ============================================================================
// banked_regfile_pkg : mode encodings and physical register index map
// Revision: 1.0
// ============================================================================
`default_nettype none

package banked_regfile_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_MON = 5'b10110;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_HYP = 5'b11010;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  typedef logic [5:0] phys_idx_t;

  localparam int NUM_PHYS = 34;

  // 0..14 base r0-r14, 15..21 fiq r8-r14, then banked r13s, banked r14s, PC
  localparam phys_idx_t PHYS_FIQ_R8  = 6'd15;
  localparam phys_idx_t PHYS_R13_IRQ = 6'd22;
  localparam phys_idx_t PHYS_R13_SVC = 6'd23;
  localparam phys_idx_t PHYS_R13_MON = 6'd24;
  localparam phys_idx_t PHYS_R13_ABT = 6'd25;
  localparam phys_idx_t PHYS_R13_HYP = 6'd26;
  localparam phys_idx_t PHYS_R13_UND = 6'd27;
  localparam phys_idx_t PHYS_R14_IRQ = 6'd28;
  localparam phys_idx_t PHYS_R14_SVC = 6'd29;
  localparam phys_idx_t PHYS_R14_MON = 6'd30;
  localparam phys_idx_t PHYS_R14_ABT = 6'd31;
  localparam phys_idx_t PHYS_R14_UND = 6'd32;
  localparam phys_idx_t PHYS_PC      = 6'd33;
  localparam phys_idx_t PHYS_INVALID = 6'd63;

endpackage

`default_nettype wire

// File: rtl/banked_regfile_bank_map.sv
// ============================================================================
// bank_map : mode + logical address -> physical register index, plus error
// Revision: 1.0
// ============================================================================
`default_nettype none

module bank_map
  import banked_regfile_pkg::*;
(
  input  logic [4:0] mode,
  input  logic [3:0] addr,
  input  logic       is_write,
  output phys_idx_t  phys,
  output logic       err
);

  logic      w_valid;
  phys_idx_t w_r13;
  phys_idx_t w_r14;

  always_comb begin
    w_valid = 1'b1;
    w_r13   = 6'd13;
    w_r14   = 6'd14;
    case (mode)
      MODE_USR, MODE_SYS, MODE_FIQ: ;
      MODE_IRQ: begin w_r13 = PHYS_R13_IRQ; w_r14 = PHYS_R14_IRQ; end
      MODE_SVC: begin w_r13 = PHYS_R13_SVC; w_r14 = PHYS_R14_SVC; end
      MODE_MON: begin w_r13 = PHYS_R13_MON; w_r14 = PHYS_R14_MON; end
      MODE_ABT: begin w_r13 = PHYS_R13_ABT; w_r14 = PHYS_R14_ABT; end
      MODE_UND: begin w_r13 = PHYS_R13_UND; w_r14 = PHYS_R14_UND; end
      MODE_HYP: w_r13 = PHYS_R13_HYP;
      default:  w_valid = 1'b0;
    endcase
  end

  always_comb begin
    phys = PHYS_INVALID;
    err  = 1'b0;
    if (addr == 4'd15) begin
      // PC is readable in any mode but only writable through pc_we
      if (is_write) err = 1'b1;
      else          phys = PHYS_PC;
    end else if (!w_valid) begin
      if (!is_write && addr < 4'd8) phys = {2'b00, addr};
      else                          err  = 1'b1;
    end else if (mode == MODE_FIQ && addr >= 4'd8) begin
      phys = PHYS_FIQ_R8 + {3'b000, addr[2:0]};
    end else if (addr == 4'd13) begin
      phys = w_r13;
    end else if (addr == 4'd14) begin
      if (is_write && mode == MODE_HYP) err  = 1'b1;
      else                              phys = w_r14;
    end else begin
      phys = {2'b00, addr};
    end
  end

endmodule

`default_nettype wire

// File: rtl/banked_regfile.sv
// ============================================================================
// banked_regfile : mode-banked register file, registered multi-port reads
// Optional macro BANKED_REGFILE_BYPASS_EN forwards same-cycle writes to reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module banked_regfile
  import banked_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               mode,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_we,
  input  logic [DATA_W-1:0]        pc_data,
  output logic                     err_w,
  output logic                     err_r,
  input  logic                     err_clr
);

  logic [DATA_W-1:0] regs_q [NUM_PHYS];
  logic [DATA_W-1:0] regs_d [NUM_PHYS];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [DATA_W-1:0] rd_data_d [NUM_RD];
  logic              err_w_q, err_w_d;
  logic              err_r_q, err_r_d;

  phys_idx_t         w_wr_phys;
  logic              w_wr_err;
  phys_idx_t         w_rd_phys [NUM_RD];
  logic [NUM_RD-1:0] w_rd_err;

  bank_map u_wr_map (
    .mode     (mode),
    .addr     (wr_addr),
    .is_write (1'b1),
    .phys     (w_wr_phys),
    .err      (w_wr_err)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    bank_map u_rd_map (
      .mode     (mode),
      .addr     (rd_addr[4*k +: 4]),
      .is_write (1'b0),
      .phys     (w_rd_phys[k]),
      .err      (w_rd_err[k])
    );
    assign rd_data[DATA_W*k +: DATA_W] = rd_data_q[k];
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en && !w_wr_err) regs_d[w_wr_phys] = wr_data;
    if (pc_we)              regs_d[PHYS_PC]   = pc_data;

    // a fresh error wins over a simultaneous clear
    err_w_d = (err_w_q & ~err_clr) | (wr_en & w_wr_err);
    err_r_d = (err_r_q & ~err_clr) | (|w_rd_err);

    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_d[k] = '0;
      if (!w_rd_err[k]) begin
`ifdef BANKED_REGFILE_BYPASS_EN
        rd_data_d[k] = regs_d[w_rd_phys[k]];
`else
        rd_data_d[k] = regs_q[w_rd_phys[k]];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) regs_q[i] <= '0;
      for (int k = 0; k < NUM_RD; k++)   rd_data_q[k] <= '0;
      err_w_q <= 1'b0;
      err_r_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
      err_w_q   <= err_w_d;
      err_r_q   <= err_r_d;
    end
  end

  assign err_w = err_w_q;
  assign err_r = err_r_q;

endmodule

`default_nettype wire

// File: tb/tb_banked_regfile.sv
// ============================================================================
// tb_banked_regfile : directed self-checking bench for banked_regfile
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_banked_regfile;

  localparam int DATA_W = 32;
  localparam int NUM_RD = 3;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_HYP = 5'b11010;
  localparam logic [4:0] M_SYS = 5'b11111;
  localparam logic [4:0] M_BAD = 5'b00000;
  localparam logic [4:0] M_RSV = 5'b10100;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [4:0]               mode = M_USR;
  logic [4*NUM_RD-1:0]      rd_addr = '0;
  logic [DATA_W*NUM_RD-1:0] rd_data;
  logic                     wr_en = 1'b0;
  logic [3:0]               wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     pc_we = 1'b0;
  logic [DATA_W-1:0]        pc_data = '0;
  logic                     err_w;
  logic                     err_r;
  logic                     err_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  banked_regfile #(.DATA_W(DATA_W), .NUM_RD(NUM_RD)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .pc_we   (pc_we),
    .pc_data (pc_data),
    .err_w   (err_w),
    .err_r   (err_r),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] m, input logic [3:0] a, input logic [31:0] d);
    mode = m; rd_addr = '0;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic chk_ports(input string tag, input logic [31:0] exp);
    for (int k = 0; k < NUM_RD; k++)
      chk($sformatf("%s.p%0d", tag, k), rd_data[DATA_W*k +: DATA_W], exp);
  endtask

  task automatic rd(input string tag, input logic [4:0] m, input logic [3:0] a,
                    input logic [31:0] exp);
    mode = m; rd_addr = {NUM_RD{a}};
    cyc();
    chk_ports(tag, exp);
  endtask

  task automatic clear_errs;
    mode = M_USR; rd_addr = '0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk_ports("rst_rd", 32'h0);
    chk("rst_err_w", {31'h0, err_w}, 32'h0);
    chk("rst_err_r", {31'h0, err_r}, 32'h0);
    #9 rst = 1'b0;
    #4;
    rd("post_rst_r5", M_USR, 4'd5, 32'h0);

    // banking of r13/r14
    wr(M_USR, 4'd13, 32'h1111);
    wr(M_SVC, 4'd13, 32'h2222);
    rd("usr_r13", M_USR, 4'd13, 32'h1111);
    rd("svc_r13", M_SVC, 4'd13, 32'h2222);
    rd("irq_r13", M_IRQ, 4'd13, 32'h0);
    wr(M_USR, 4'd14, 32'h0E14);
    wr(M_HYP, 4'd13, 32'h4444);
    rd("hyp_r14", M_HYP, 4'd14, 32'h0E14);
    rd("hyp_r13", M_HYP, 4'd13, 32'h4444);
    rd("sys_r13", M_SYS, 4'd13, 32'h1111);
    chk("hyp_rd_noerr", {31'h0, err_r}, 32'h0);

    // fiq banking
    wr(M_USR, 4'd9, 32'hA5);
    wr(M_FIQ, 4'd9, 32'h5A);
    rd("fiq_r9", M_FIQ, 4'd9, 32'h5A);
    rd("usr_r9", M_USR, 4'd9, 32'hA5);
    wr(M_FIQ, 4'd7, 32'h777);
    rd("usr_r7", M_USR, 4'd7, 32'h777);
    rd("fiq_r13", M_FIQ, 4'd13, 32'h0);

    pc_we = 1'b1; pc_data = 32'h40;
    cyc();
    pc_we = 1'b0;
    rd("pc", M_USR, 4'd15, 32'h40);

    // write errors
    chk("no_err_w", {31'h0, err_w}, 32'h0);
    wr(M_USR, 4'd15, 32'hDEAD);
    chk("err_w_r15", {31'h0, err_w}, 32'h1);
    rd("pc_keep", M_USR, 4'd15, 32'h40);
    clear_errs();
    chk("err_w_clr", {31'h0, err_w}, 32'h0);
    err_clr = 1'b1;
    wr(M_HYP, 4'd14, 32'h0BAD);
    err_clr = 1'b0;
    chk("err_w_hyp14", {31'h0, err_w}, 32'h1);
    rd("r14_keep", M_USR, 4'd14, 32'h0E14);
    clear_errs();
    wr(M_USR, 4'd2, 32'h22);
    chk("err_w_legal", {31'h0, err_w}, 32'h0);
    wr(M_RSV, 4'd2, 32'h99);
    chk("err_w_rsv", {31'h0, err_w}, 32'h1);
    rd("r2_keep", M_USR, 4'd2, 32'h22);
    clear_errs();

    // invalid-mode reads
    wr(M_USR, 4'd3, 32'h33);
    wr(M_USR, 4'd10, 32'h1010);
    rd("bad_r10", M_BAD, 4'd10, 32'h0);
    chk("err_r_set", {31'h0, err_r}, 32'h1);
    rd("bad_r3", M_BAD, 4'd3, 32'h33);
    rd("bad_pc", M_RSV, 4'd15, 32'h40);
    clear_errs();
    chk("err_r_clr", {31'h0, err_r}, 32'h0);
    rd("usr_r10", M_USR, 4'd10, 32'h1010);

    // same-cycle write and read
    wr(M_USR, 4'd4, 32'h44);
    mode = M_USR; rd_addr = {NUM_RD{4'd4}};
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h77;
    cyc();
    wr_en = 1'b0;
`ifdef BANKED_REGFILE_BYPASS_EN
    chk_ports("same_r4", 32'h77);
`else
    chk_ports("same_r4", 32'h44);
`endif
    rd("after_r4", M_USR, 4'd4, 32'h77);
    rd_addr = {NUM_RD{4'd15}};
    pc_we = 1'b1; pc_data = 32'h100;
    cyc();
    pc_we = 1'b0;
`ifdef BANKED_REGFILE_BYPASS_EN
    chk_ports("same_pc", 32'h100);
`else
    chk_ports("same_pc", 32'h40);
`endif
    rd("after_pc", M_USR, 4'd15, 32'h100);

    // simultaneous register and PC write, distinct port addresses
    mode = M_USR; rd_addr = '0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h55;
    pc_we = 1'b1; pc_data = 32'h200;
    cyc();
    wr_en = 1'b0; pc_we = 1'b0;
    rd_addr = {4'd4, 4'd15, 4'd5};
    cyc();
    chk("dual_p0_r5", rd_data[0 +: 32], 32'h55);
    chk("dual_p1_pc", rd_data[32 +: 32], 32'h200);
    chk("dual_p2_r4", rd_data[64 +: 32], 32'h77);

    // asynchronous reset between edges
    wr(M_USR, 4'd15, 32'h1);
    rd("pre_rst_bad", M_BAD, 4'd10, 32'h0);
    rd("pre_rst_r4", M_USR, 4'd4, 32'h77);
    #2 rst = 1'b1;
    #1;
    chk_ports("arst_rd", 32'h0);
    chk("arst_err_w", {31'h0, err_w}, 32'h0);
    chk("arst_err_r", {31'h0, err_r}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    rd("z_r4", M_USR, 4'd4, 32'h0);
    rd("z_r13", M_USR, 4'd13, 32'h0);
    rd("z_svc13", M_SVC, 4'd13, 32'h0);
    rd("z_fiq9", M_FIQ, 4'd9, 32'h0);
    rd("z_pc", M_USR, 4'd15, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
